// File: rtl/keypad_time_loader_pkg.sv
// Shared definitions for the keypad time-entry path: widths, defaults, FSM states
// and key kinds. The countdown counter top level imports this as well.
package keypad_time_loader_pkg;

   localparam int KEY_W          = 10;
   localparam int BCD_W          = 4;
   localparam int MAX_DIGITS_DEF = 3;
   localparam int DEBOUNCE_DEF   = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_LOAD     = 3'd2,
      ST_CLEAR    = 3'd3,
      ST_RELEASE  = 3'd4
   } state_t;

   typedef enum logic {
      KIND_DIG = 1'b0,
      KIND_CLR = 1'b1
   } kind_t;

endpackage

// File: rtl/keypad_time_loader_encoder.sv
// One-hot digit keypad to BCD encoder. valid is low when no key or several keys
// are pressed, so ambiguous chords never reach the loader.
module keypad_time_loader_encoder
   import keypad_time_loader_pkg::*;
(
   input  logic [KEY_W-1:0] keys,
   output logic [BCD_W-1:0] code,
   output logic             valid
);

   logic [3:0] n_set;

   always_comb begin
      code  = '0;
      n_set = '0;
      for (int i = 0; i < KEY_W; i++) begin
         if (keys[i]) begin
            code  = BCD_W'(i);
            n_set = n_set + 4'd1;
         end
      end
      valid = (n_set == 4'd1);
   end

endmodule

// File: rtl/keypad_time_loader.sv
// Keypad-side driver of the countdown chain: debounces keys, then issues one-cycle
// loadn (digit) or clrn (clear) strobes and tracks how many digits were entered.
//
// state    | meaning
// IDLE     | waiting for clear key or a single digit key
// DEBOUNCE | counting identical samples of the captured key
// LOAD     | loadn low for one cycle, data holds the digit
// CLEAR    | clrn low for one cycle, count and data cleared
// RELEASE  | waiting for all keys up (no auto-repeat)
module keypad_time_loader
   import keypad_time_loader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter int MAX_DIGITS      = MAX_DIGITS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] keypad,
   input  logic             clear_key,
   input  logic             running,
   input  logic             zero,
   output logic [BCD_W-1:0] data,
   output logic             loadn,
   output logic             clrn,
   output logic [1:0]       digit_count,
   output logic             digits_full
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [1:0]      CNT_MAX = 2'(MAX_DIGITS);

   state_t           state_q, state_d;
   kind_t            kind_q, kind_d;
   logic [BCD_W-1:0] code_q, code_d;
   logic [KEY_W:0]   sample_q, sample_d;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [BCD_W-1:0] data_q, data_d;
   logic             loadn_q, loadn_d;
   logic             clrn_q, clrn_d;
   logic [1:0]       count_q, count_d;
   logic             full_q, full_d;

   logic [BCD_W-1:0] enc_code;
   logic             enc_valid;
   logic [KEY_W:0]   cur_sample;

   assign cur_sample = {clear_key, keypad};

   keypad_time_loader_encoder u_encoder (
      .keys  (keypad),
      .code  (enc_code),
      .valid (enc_valid)
   );

   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      code_d   = code_q;
      sample_d = sample_q;
      db_cnt_d = db_cnt_q;
      data_d   = data_q;
      loadn_d  = 1'b1;
      clrn_d   = 1'b1;
      count_d  = count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (clear_key) begin
               state_d  = ST_DEBOUNCE;
               kind_d   = KIND_CLR;
               sample_d = cur_sample;
               db_cnt_d = DB_W'(1);
            end else if (!running && enc_valid) begin
               state_d  = ST_DEBOUNCE;
               kind_d   = KIND_DIG;
               code_d   = enc_code;
               sample_d = cur_sample;
               db_cnt_d = DB_W'(1);
            end
         end
         ST_DEBOUNCE: begin
            // the decision edge acts on the DEBOUNCE_CYCLES samples already seen
            if (kind_q == KIND_DIG && running) begin
               state_d = ST_IDLE;
            end else if (db_cnt_q == DB_MAX) begin
               if (kind_q == KIND_CLR) begin
                  state_d = ST_CLEAR;
                  clrn_d  = 1'b0;
                  count_d = '0;
                  data_d  = '0;
               end else if (count_q < CNT_MAX) begin
                  state_d = ST_LOAD;
                  loadn_d = 1'b0;
                  data_d  = code_q;
                  count_d = count_q + 2'd1;
               end else begin
                  state_d = ST_RELEASE;
               end
            end else if (cur_sample != sample_q) begin
               state_d = ST_IDLE;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         ST_LOAD:    state_d = ST_RELEASE;
         ST_CLEAR:   state_d = ST_RELEASE;
         ST_RELEASE: if (cur_sample == '0) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // countdown finished overrides a coincident digit load
      if (running && zero) count_d = '0;
      full_d = (count_d == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         kind_q   <= KIND_DIG;
         code_q   <= '0;
         sample_q <= '0;
         db_cnt_q <= '0;
         data_q   <= '0;
         loadn_q  <= 1'b1;
         clrn_q   <= 1'b1;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         code_q   <= code_d;
         sample_q <= sample_d;
         db_cnt_q <= db_cnt_d;
         data_q   <= data_d;
         loadn_q  <= loadn_d;
         clrn_q   <= clrn_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   assign data        = data_q;
   assign loadn       = loadn_q;
   assign clrn        = clrn_q;
   assign digit_count = count_q;
   assign digits_full = full_q;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Bench for keypad_time_loader: directed scenarios plus randomized key sequences,
// all checked against a key-press level reference model.
module tb_keypad_time_loader;

   localparam int DEB  = 4;
   localparam int MAXD = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] keypad = '0;
   logic       clear_key = 1'b0;
   logic       running = 1'b0;
   logic       zero = 1'b0;
   logic [3:0] data;
   logic       loadn, clrn;
   logic [1:0] digit_count;
   logic       digits_full;

   int n_vec = 0;
   int n_bad = 0;

   keypad_time_loader dut (
      .clk         (clk),
      .rst         (rst),
      .keypad      (keypad),
      .clear_key   (clear_key),
      .running     (running),
      .zero        (zero),
      .data        (data),
      .loadn       (loadn),
      .clrn        (clrn),
      .digit_count (digit_count),
      .digits_full (digits_full)
   );

   always #5 clk = ~clk;

   // reference model: a press must be seen DEB times in a row, then one strobe
   // cycle, then all keys must be up before the next press counts
   int         m_streak = 0;
   logic [10:0] m_tracked = '0;
   bit         m_is_clr = 0;
   logic [3:0] m_code = '0;
   bit         m_skip = 0;
   bit         m_wait = 0;
   logic [3:0] m_data = '0;
   logic       m_loadn = 1'b1;
   logic       m_clrn = 1'b1;
   int         m_count = 0;
   logic       m_full = 1'b0;

   task automatic model_edge();
      logic [10:0] s;
      s = {clear_key, keypad};
      if (rst) begin
         m_streak = 0; m_skip = 0; m_wait = 0;
         m_data = '0; m_loadn = 1'b1; m_clrn = 1'b1; m_count = 0; m_full = 1'b0;
         return;
      end
      m_loadn = 1'b1;
      m_clrn  = 1'b1;
      if (m_skip) begin
         m_skip = 0;
         m_wait = 1;
      end else if (m_wait) begin
         if (s == 11'd0) m_wait = 0;
      end else if (m_streak == 0) begin
         if (clear_key) begin
            m_streak = 1; m_is_clr = 1; m_tracked = s;
         end else if (!running && $countones(keypad) == 1) begin
            m_streak = 1; m_is_clr = 0; m_tracked = s;
            for (int i = 0; i < 10; i++) if (keypad[i]) m_code = 4'(i);
         end
      end else begin
         if (!m_is_clr && running) m_streak = 0;
         else if (m_streak == DEB) begin
            m_streak = 0;
            if (m_is_clr) begin
               m_clrn = 1'b0; m_count = 0; m_data = '0; m_skip = 1;
            end else if (m_count < MAXD) begin
               m_loadn = 1'b0; m_data = m_code; m_count++; m_skip = 1;
            end else m_wait = 1;
         end else if (s != m_tracked) m_streak = 0;
         else m_streak++;
      end
      if (running && zero) m_count = 0;
      m_full = (m_count == MAXD);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   int         obs_loadn_lows, obs_clrn_lows, obs_overlap, obs_diff;
   logic [3:0] obs_load_data;
   logic [8:0] obs_got, obs_exp;

   // drives one press (hold cycles) then release cycles, recording what was seen
   task automatic press(input logic [9:0] kp, input logic clr, input int hold, input int rel);
      obs_loadn_lows = 0; obs_clrn_lows = 0; obs_overlap = 0; obs_diff = 0;
      obs_load_data = 4'hF; obs_got = '0; obs_exp = '0;
      for (int c = 0; c < hold + rel; c++) begin
         keypad    = (c < hold) ? kp : 10'd0;
         clear_key = (c < hold) ? clr : 1'b0;
         step();
         if (!loadn) begin obs_loadn_lows++; obs_load_data = data; end
         if (!clrn) obs_clrn_lows++;
         if (!loadn && !clrn) obs_overlap++;
         if ({data, loadn, clrn, digit_count, digits_full} !==
             {m_data, m_loadn, m_clrn, m_count[1:0], m_full}) begin
            if (obs_diff == 0) begin
               obs_got = {data, loadn, clrn, digit_count, digits_full};
               obs_exp = {m_data, m_loadn, m_clrn, m_count[1:0], m_full};
            end
            obs_diff++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_vec++;
      if ({data, loadn, clrn, digit_count, digits_full} !== {4'd0, 1'b1, 1'b1, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset: got %h required %h", {data, loadn, clrn, digit_count, digits_full},
                  {4'd0, 1'b1, 1'b1, 2'd0, 1'b0});
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_digit();
      keypad = 10'd1 << 5;
      for (int k = 0; k < 6; k++) begin
         step();
         n_vec++;
         if (loadn !== ((k == 4) ? 1'b0 : 1'b1) || (k == 4 && data !== 4'd5)) begin
            n_bad++;
            $display("FAIL single_digit cycle %0d: loadn %b data %0d, required loadn %b data 5",
                     k, loadn, data, (k == 4) ? 1'b0 : 1'b1);
         end
      end
      keypad = '0;
      step(); step();
      n_vec++;
      if (digit_count !== 2'd1) begin
         n_bad++;
         $display("FAIL single_digit_count: got %0d required 1", digit_count);
      end
   endtask

   task automatic test_fill();
      press('0, 1'b1, 6, 3);
      for (int d = 1; d <= 3; d++) begin
         press(10'd1 << d, 1'b0, 6, 3);
         n_vec++;
         if (obs_loadn_lows != 1 || obs_load_data !== 4'(d) || obs_diff != 0) begin
            n_bad++;
            $display("FAIL fill_digit%0d: strobes %0d data %0d diffs %0d, required 1 strobe data %0d 0 diffs",
                     d, obs_loadn_lows, obs_load_data, obs_diff, d);
         end
      end
      press(10'd1 << 4, 1'b0, 6, 3);
      n_vec++;
      if (obs_loadn_lows != 0 || digits_full !== 1'b1 || digit_count !== 2'd3) begin
         n_bad++;
         $display("FAIL fill_overflow: strobes %0d full %b count %0d, required 0 strobes full 1 count 3",
                  obs_loadn_lows, digits_full, digit_count);
      end
   endtask

   task automatic test_glitch();
      press('0, 1'b1, 6, 3);
      press(10'd1 << 7, 1'b0, 2, 6);
      n_vec++;
      if (obs_loadn_lows != 0 || obs_diff != 0 || digit_count !== 2'd0) begin
         n_bad++;
         $display("FAIL glitch: strobes %0d diffs %0d count %0d, required 0 strobes 0 diffs count 0",
                  obs_loadn_lows, obs_diff, digit_count);
      end
      press(10'd1 << 6, 1'b0, 6, 3);
      n_vec++;
      if (obs_loadn_lows != 1 || obs_load_data !== 4'd6) begin
         n_bad++;
         $display("FAIL glitch_recover: strobes %0d data %0d, required 1 strobe data 6",
                  obs_loadn_lows, obs_load_data);
      end
   endtask

   task automatic test_invalid_keys();
      press(10'b0000100100, 1'b0, 8, 3);
      n_vec++;
      if (obs_loadn_lows != 0 || obs_diff != 0) begin
         n_bad++;
         $display("FAIL multi_key: strobes %0d diffs %0d, required 0 and 0", obs_loadn_lows, obs_diff);
      end
      running = 1'b1;
      press(10'd1 << 9, 1'b0, 8, 3);
      running = 1'b0;
      n_vec++;
      if (obs_loadn_lows != 0 || obs_diff != 0) begin
         n_bad++;
         $display("FAIL running_key: strobes %0d diffs %0d, required 0 and 0", obs_loadn_lows, obs_diff);
      end
   endtask

   task automatic test_clear_running();
      press('0, 1'b1, 6, 3);
      press(10'd1 << 2, 1'b0, 6, 3);
      press(10'd1 << 8, 1'b0, 6, 3);
      n_vec++;
      if (digit_count !== 2'd2) begin
         n_bad++;
         $display("FAIL clear_setup_count: got %0d required 2", digit_count);
      end
      running = 1'b1;
      zero    = 1'b0;
      press('0, 1'b1, 6, 3);
      running = 1'b0;
      n_vec++;
      if (obs_clrn_lows != 1 || obs_loadn_lows != 0 || digit_count !== 2'd0 || obs_diff != 0) begin
         n_bad++;
         $display("FAIL clear_running: clrn lows %0d loadn lows %0d count %0d diffs %0d, required 1 0 0 0",
                  obs_clrn_lows, obs_loadn_lows, digit_count, obs_diff);
      end
   endtask

   task automatic test_reset_during_load();
      keypad = 10'd1 << 8;
      for (int k = 0; k < 5; k++) step();
      n_vec++;
      if (loadn !== 1'b0 || data !== 4'd8) begin
         n_bad++;
         $display("FAIL rst_load_setup: loadn %b data %0d, required 0 and 8", loadn, data);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_vec++;
      if ({data, loadn, clrn, digit_count} !== {4'd0, 1'b1, 1'b1, 2'd0}) begin
         n_bad++;
         $display("FAIL rst_during_load: got %h required %h", {data, loadn, clrn, digit_count},
                  {4'd0, 1'b1, 1'b1, 2'd0});
      end
      keypad = '0;
      step();
      press(10'd1 << 3, 1'b0, 6, 3);
      n_vec++;
      if (obs_loadn_lows != 1 || obs_load_data !== 4'd3 || digit_count !== 2'd1) begin
         n_bad++;
         $display("FAIL rst_recover: strobes %0d data %0d count %0d, required 1 3 1",
                  obs_loadn_lows, obs_load_data, digit_count);
      end
   endtask

   task automatic test_random();
      logic [9:0] kp;
      logic       clr;
      int         sel;
      for (int seg = 0; seg < 80; seg++) begin
         sel = $urandom_range(0, 9);
         clr = 1'b0;
         kp  = '0;
         if (sel == 0) clr = 1'b1;
         else if (sel <= 6) kp = 10'd1 << $urandom_range(0, 9);
         else if (sel == 7) kp = (10'd1 << $urandom_range(0, 4)) | (10'd1 << $urandom_range(5, 9));
         running = ($urandom_range(0, 3) == 0);
         zero    = 1'($urandom_range(0, 1));
         press(kp, clr, $urandom_range(1, 7), $urandom_range(0, 3));
         n_vec++;
         if (obs_diff != 0 || obs_overlap != 0) begin
            n_bad++;
            $display("FAIL random_seg%0d: %0d diffs (first got %h required %h), overlap %0d",
                     seg, obs_diff, obs_got, obs_exp, obs_overlap);
         end
      end
      running = 1'b0;
      zero    = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_digit();
      test_fill();
      test_glitch();
      test_invalid_keys();
      test_clear_running();
      test_reset_during_load();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
